// File: rtl/mem_arbiter.sv
// Two-to-one memory arbiter: serializes instruction fetches and data accesses
// onto one SRAM-like bus, one transaction at a time, data before fetch.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        stall_req,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;

    state_t state;
    logic   own;  // 0 = fetch port owns the bus, 1 = data port

    // Handshake: bus_req is the address-phase valid, held with stable fields
    // until bus_addr_ok (ready) is seen in ADDR; bus_data_ok then closes the
    // data phase. The core holds *_req high until the matching *_done pulse.

    // kseg0/kseg1 are folded onto the low 512 MiB; everything else passes through.
    function automatic logic [31:0] map_addr(input logic [31:0] va);
        return (va[31:30] == 2'b10) ? {3'b000, va[28:0]} : va;
    endfunction

    assign stall_req = (i_req & ~i_done) | (d_req & ~d_done);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            own       <= 1'b0;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_size  <= 2'b00;
            bus_wstrb <= 4'b0000;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            i_rdata   <= 32'h0;
            d_rdata   <= 32'h0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req) begin
                        own       <= 1'b1;
                        bus_req   <= 1'b1;
                        bus_wr    <= d_wr;
                        bus_size  <= d_size;
                        bus_wstrb <= d_wstrb;
                        bus_addr  <= map_addr(d_addr);
                        bus_wdata <= d_wdata;
                        state     <= ADDR;
                    end else if (i_req) begin
                        own       <= 1'b0;
                        bus_req   <= 1'b1;
                        bus_wr    <= 1'b0;
                        bus_size  <= 2'b10;
                        bus_wstrb <= 4'b0000;
                        bus_addr  <= map_addr(i_addr);
                        bus_wdata <= 32'h0;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bus_data_ok) begin
                        if (own) begin
                            if (!bus_wr) d_rdata <= bus_rdata;
                            d_done <= 1'b1;
                        end else begin
                            if (!bus_wr) i_rdata <= bus_rdata;
                            i_done <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    // Nothing is accepted here, giving the core one edge to drop its request.
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: each scenario task drives the core and bus
// sides cycle by cycle and checks against hand-computed values.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_wr;
    logic [31:0] i_addr, d_addr, d_wdata, bus_rdata;
    logic [1:0]  d_size;
    logic [3:0]  d_wstrb;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
    logic        i_done, d_done, stall_req, bus_req, bus_wr;
    logic [1:0]  bus_size, dbg_state;
    logic [3:0]  bus_wstrb;

    int vectors = 0;
    int miscompares = 0;
    int bus_req_rises = 0;
    int i_done_cnt = 0;
    int d_done_cnt = 0;
    logic bus_req_q = 1'b0;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
        .stall_req(stall_req), .bus_req(bus_req), .bus_wr(bus_wr),
        .bus_size(bus_size), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // monitors sampling pre-edge values
    always @(posedge clk) begin
        if (bus_req && !bus_req_q) bus_req_rises++;
        if (i_done) i_done_cnt++;
        if (d_done) d_done_cnt++;
        bus_req_q <= bus_req;
    end

    // driver tasks: inputs change 1 ns after the rising edge, checks at the falling edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_size = 0; d_wstrb = 0;
        d_addr = 0; d_wdata = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        repeat (2) cyc();
        mid();
        vectors++;
        if ({bus_req, bus_wr, i_done, d_done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b required 0000", {bus_req, bus_wr, i_done, d_done});
        end
        vectors++;
        if ({bus_size, bus_wstrb, bus_addr, bus_wdata} !== 70'h0) begin
            miscompares++;
            $display("FAIL reset_bus_fields: got size=%b wstrb=%b addr=%h wdata=%h required all 0",
                     bus_size, bus_wstrb, bus_addr, bus_wdata);
        end
        vectors++;
        if ({i_rdata, d_rdata} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got i=%h d=%h required 0", i_rdata, d_rdata);
        end
        vectors++;
        if (dbg_state !== 2'd0 || stall_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got state=%0d stall=%b required 0/0", dbg_state, stall_req);
        end
        cyc();
        reset = 0;
        cyc();
    endtask

    task automatic test_single_fetch();
        int r0;
        r0 = bus_req_rises;
        cyc(); i_req = 1; i_addr = 32'hBFC0_0000;                   // cycle 0
        mid();
        vectors++;
        if (stall_req !== 1'b1 || bus_req !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_c0: got stall=%b bus_req=%b required 1/0", stall_req, bus_req);
        end
        cyc(); bus_addr_ok = 1;                                     // cycle 1
        mid();
        vectors++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h1FC0_0000 || bus_size !== 2'b10 || bus_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_addr_phase: got req=%b addr=%h size=%b wr=%b required 1/1fc00000/10/0",
                     bus_req, bus_addr, bus_size, bus_wr);
        end
        cyc(); bus_addr_ok = 0;                                     // cycle 2
        mid();
        vectors++;
        if (bus_req !== 1'b0 || stall_req !== 1'b1 || dbg_state !== 2'd2) begin
            miscompares++;
            $display("FAIL fetch_wait_data: got req=%b stall=%b state=%0d required 0/1/2",
                     bus_req, stall_req, dbg_state);
        end
        cyc(); bus_data_ok = 1; bus_rdata = 32'h3C08_0001;          // cycle 3
        mid();
        vectors++;
        if (i_done !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_early_done: got i_done=%b required 0", i_done);
        end
        cyc(); bus_data_ok = 0; bus_rdata = 0;                      // cycle 4
        mid();
        vectors++;
        if (i_done !== 1'b1 || i_rdata !== 32'h3C08_0001 || stall_req !== 1'b0 || d_done !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_done: got i_done=%b i_rdata=%h stall=%b d_done=%b required 1/3c080001/0/0",
                     i_done, i_rdata, stall_req, d_done);
        end
        cyc(); i_req = 0;                                           // cycle 5
        mid();
        vectors++;
        if (i_done !== 1'b0 || i_rdata !== 32'h3C08_0001 || bus_req_rises - r0 !== 1) begin
            miscompares++;
            $display("FAIL fetch_after: got i_done=%b i_rdata=%h req_rises=%0d required 0/3c080001/1",
                     i_done, i_rdata, bus_req_rises - r0);
        end
    endtask

    task automatic test_priority();
        cyc();                                                      // cycle 0
        i_req = 1; i_addr = 32'h0040_0000;
        d_req = 1; d_wr = 0; d_size = 2'b10; d_wstrb = 4'b0000; d_addr = 32'h8000_0010;
        cyc(); bus_addr_ok = 1;                                     // cycle 1
        mid();
        vectors++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h0000_0010 || bus_wr !== 1'b0 || bus_size !== 2'b10) begin
            miscompares++;
            $display("FAIL prio_data_first: got req=%b addr=%h wr=%b size=%b required 1/00000010/0/10",
                     bus_req, bus_addr, bus_wr, bus_size);
        end
        cyc(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hDEAD_BEEF;  // cycle 2
        cyc(); bus_data_ok = 0; bus_rdata = 0;                      // cycle 3
        mid();
        vectors++;
        if (d_done !== 1'b1 || d_rdata !== 32'hDEAD_BEEF || i_done !== 1'b0 || stall_req !== 1'b1) begin
            miscompares++;
            $display("FAIL prio_d_done: got d_done=%b d_rdata=%h i_done=%b stall=%b required 1/deadbeef/0/1",
                     d_done, d_rdata, i_done, stall_req);
        end
        cyc(); d_req = 0;                                           // cycle 4: IDLE
        mid();
        vectors++;
        if (bus_req !== 1'b0 || dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL prio_gap: got req=%b state=%0d required 0/0", bus_req, dbg_state);
        end
        cyc(); bus_addr_ok = 1;                                     // cycle 5
        mid();
        vectors++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h0040_0000) begin
            miscompares++;
            $display("FAIL prio_fetch_start: got req=%b addr=%h required 1/00400000", bus_req, bus_addr);
        end
        cyc(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h1234_5678;  // cycle 6
        cyc(); bus_data_ok = 0; bus_rdata = 0;                      // cycle 7: 8th cycle from request
        mid();
        vectors++;
        if (i_done !== 1'b1 || i_rdata !== 32'h1234_5678 || d_rdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL prio_i_done: got i_done=%b i_rdata=%h d_rdata=%h required 1/12345678/deadbeef",
                     i_done, i_rdata, d_rdata);
        end
        cyc(); i_req = 0;
    endtask

    task automatic test_store();
        int d0;
        d0 = d_done_cnt;
        cyc();
        d_req = 1; d_wr = 1; d_size = 2'b01; d_wstrb = 4'b0011;
        d_addr = 32'h0000_2002; d_wdata = 32'h0000_ABCD;
        cyc(); bus_addr_ok = 1;
        mid();
        vectors++;
        if (bus_wr !== 1'b1 || bus_size !== 2'b01 || bus_wstrb !== 4'b0011 ||
            bus_addr !== 32'h0000_2002 || bus_wdata !== 32'h0000_ABCD) begin
            miscompares++;
            $display("FAIL store_fields: got wr=%b size=%b wstrb=%b addr=%h wdata=%h required 1/01/0011/00002002/0000abcd",
                     bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata);
        end
        cyc(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hFFFF_FFFF;
        cyc(); bus_data_ok = 0; bus_rdata = 0;
        mid();
        vectors++;
        if (d_done !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL store_done: got d_done=%b d_rdata=%h required 1/deadbeef", d_done, d_rdata);
        end
        cyc(); d_req = 0; d_wr = 0;
        mid();
        vectors++;
        if (d_done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL store_pulses: got %0d d_done pulses required 1", d_done_cnt - d0);
        end
    endtask

    task automatic test_slow_bus();
        cyc(); i_req = 1; i_addr = 32'hA000_1000;
        for (int i = 0; i < 5; i++) begin
            cyc();
            mid();
            vectors++;
            if (bus_req !== 1'b1 || bus_addr !== 32'h0000_1000 || bus_size !== 2'b10 || stall_req !== 1'b1) begin
                miscompares++;
                $display("FAIL slow_addr_wait[%0d]: got req=%b addr=%h size=%b stall=%b required 1/00001000/10/1",
                         i, bus_req, bus_addr, bus_size, stall_req);
            end
        end
        cyc(); bus_addr_ok = 1;
        for (int i = 0; i < 7; i++) begin
            cyc(); bus_addr_ok = 0;
            mid();
            vectors++;
            if (bus_req !== 1'b0 || bus_addr !== 32'h0000_1000 || stall_req !== 1'b1 || i_done !== 1'b0) begin
                miscompares++;
                $display("FAIL slow_data_wait[%0d]: got req=%b addr=%h stall=%b done=%b required 0/00001000/1/0",
                         i, bus_req, bus_addr, stall_req, i_done);
            end
        end
        bus_data_ok = 1; bus_rdata = 32'hCAFE_F00D;
        cyc(); bus_data_ok = 0; bus_rdata = 0;
        mid();
        vectors++;
        if (i_done !== 1'b1 || i_rdata !== 32'hCAFE_F00D || stall_req !== 1'b0) begin
            miscompares++;
            $display("FAIL slow_done: got done=%b rdata=%h stall=%b required 1/cafef00d/0", i_done, i_rdata, stall_req);
        end
        cyc(); i_req = 0;
    endtask

    task automatic test_reset_mid();
        int c0;
        cyc(); i_req = 1; i_addr = 32'h0000_0100;
        cyc(); bus_addr_ok = 1;
        cyc(); bus_addr_ok = 0;                                     // DATA
        c0 = i_done_cnt + d_done_cnt;
        #1 reset = 1;
        #1;
        vectors++;
        if (bus_req !== 1'b0 || dbg_state !== 2'd0 || bus_addr !== 32'h0 || i_rdata !== 32'h0 ||
            d_rdata !== 32'h0 || i_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: got req=%b state=%0d addr=%h i_rdata=%h d_rdata=%h done=%b required all 0",
                     bus_req, dbg_state, bus_addr, i_rdata, d_rdata, i_done);
        end
        bus_data_ok = 1; bus_rdata = 32'h7777_7777;
        repeat (2) cyc();
        bus_data_ok = 0; bus_rdata = 0;
        reset = 0;
        mid();
        vectors++;
        if (i_done_cnt + d_done_cnt !== c0 || bus_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_done: got %0d extra done pulses req=%b required 0/0",
                     i_done_cnt + d_done_cnt - c0, bus_req);
        end
        cyc(); bus_addr_ok = 1;
        mid();
        vectors++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h0000_0100) begin
            miscompares++;
            $display("FAIL rst_restart: got req=%b addr=%h required 1/00000100", bus_req, bus_addr);
        end
        cyc(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0BAD_F00D;
        cyc(); bus_data_ok = 0; bus_rdata = 0;
        mid();
        vectors++;
        if (i_done !== 1'b1 || i_rdata !== 32'h0BAD_F00D) begin
            miscompares++;
            $display("FAIL rst_restart_done: got done=%b rdata=%h required 1/0badf00d", i_done, i_rdata);
        end
        cyc(); i_req = 0;
    endtask

    task automatic test_spurious();
        int c0;
        c0 = i_done_cnt + d_done_cnt;
        cyc(); bus_data_ok = 1; bus_rdata = 32'h1111_1111;          // data_ok in IDLE
        cyc(); bus_data_ok = 0; bus_rdata = 0;
        mid();
        vectors++;
        if (dbg_state !== 2'd0 || i_done !== 1'b0 || d_done !== 1'b0 || bus_req !== 1'b0) begin
            miscompares++;
            $display("FAIL spur_idle: got state=%0d i_done=%b d_done=%b req=%b required 0/0/0/0",
                     dbg_state, i_done, d_done, bus_req);
        end
        cyc(); d_req = 1; d_wr = 0; d_size = 2'b10; d_wstrb = 0; d_addr = 32'h0000_0040;
        cyc(); bus_data_ok = 1; bus_rdata = 32'h2222_2222;          // data_ok in ADDR
        cyc(); bus_data_ok = 0; bus_rdata = 0;
        mid();
        vectors++;
        if (dbg_state !== 2'd1 || bus_req !== 1'b1 || d_done !== 1'b0) begin
            miscompares++;
            $display("FAIL spur_addr: got state=%0d req=%b done=%b required 1/1/0", dbg_state, bus_req, d_done);
        end
        bus_addr_ok = 1;
        cyc(); bus_addr_ok = 1;                                     // addr_ok in DATA
        cyc(); bus_addr_ok = 0;
        mid();
        vectors++;
        if (dbg_state !== 2'd2 || bus_req !== 1'b0 || d_done !== 1'b0) begin
            miscompares++;
            $display("FAIL spur_data: got state=%0d req=%b done=%b required 2/0/0", dbg_state, bus_req, d_done);
        end
        bus_data_ok = 1; bus_rdata = 32'h55AA_55AA;
        cyc(); bus_data_ok = 0; bus_rdata = 0;
        mid();
        vectors++;
        if (d_done !== 1'b1 || d_rdata !== 32'h55AA_55AA || i_done_cnt + d_done_cnt - c0 !== 0) begin
            miscompares++;
            $display("FAIL spur_done: got done=%b rdata=%h prior pulses=%0d required 1/55aa55aa/0",
                     d_done, d_rdata, i_done_cnt + d_done_cnt - c0);
        end
        cyc(); d_req = 0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_priority();
        test_store();
        test_slow_bus();
        test_reset_mid();
        test_spurious();
        repeat (2) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter between the pipeline core and the external SRAM-like bus. It replaces the core's direct instruction ROM and `data_ram` ports. Each cycle it accepts either an instruction-fetch request or a data load/store request and runs one bus transaction at a time. It returns read data to the requesting port and raises a stall request to the pipeline controller while any request is outstanding.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- i_req  in  1  fetch request; held high by core until i_done
- i_addr  in  32  fetch virtual address, word aligned
- i_rdata  out  32  fetched instruction; valid when i_done=1, held until next fetch completion
- i_done  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held high by core until d_done
- d_wr  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word
- d_wstrb  in  4  byte enables for store (store_control encoding)
- d_addr  in  32  data virtual address
- d_wdata  in  32  store data
- d_rdata  out  32  load data; valid when d_done=1, held until next data completion
- d_done  out  1  one-cycle completion pulse for data
- stall_req  out  1  to pipeline controller; (i_req & ~i_done) | (d_req & ~d_done), combinational
- bus_req  out  1  bus request, registered
- bus_wr, bus_size[1:0], bus_wstrb[3:0], bus_addr[31:0], bus_wdata[31:0]  out  registered transaction fields, stable while bus_req=1
- bus_addr_ok  in  1  bus accepted request this cycle
- bus_data_ok  in  1  bus returns read data or write completion this cycle
- bus_rdata  in  32  read data, valid with bus_data_ok

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. Owner register `own` (0 = I, 1 = D).
- IDLE:
  - If d_req, latch the d_* fields into the bus_* registers, set own=1, and go to ADDR.
  - Else if i_req, latch with bus_wr=0, bus_size=10, bus_wstrb=0000, and bus_wdata=0; set own=0 and go to ADDR.
  - Data always has priority over fetch when both are requested.
- Address mapping applied at latch time:
  - addr[31:29] = 100 or 101 (kseg0/kseg1): bus_addr = {3'b000, addr[28:0]}.
  - Otherwise: addr is passed through unchanged.
- ADDR: bus_req=1. On bus_addr_ok, bus_req drops at the next edge and the FSM goes to DATA.
- DATA: bus_req=0. On bus_data_ok:
  - For a load or fetch, capture bus_rdata into the owner's rdata register.
  - For a store, leave the owner's rdata unchanged.
  - Go to RESP.
- RESP: pulse the owner's done for exactly one cycle, then go to IDLE. No new request is accepted in RESP, so the core has one edge to drop or change its request.
- Once a transaction is accepted it always runs to completion; deasserting req mid-transaction does not abort it, and done still pulses.
- bus_data_ok while in ADDR or IDLE, and bus_addr_ok outside ADDR, are ignored.

## Timing
- Reset values: state IDLE; bus_req, bus_wr, i_done, d_done = 0; bus_size, bus_wstrb = 0; bus_addr, bus_wdata, i_rdata, d_rdata = 0.
- Reset asserted mid-transaction: the FSM returns to IDLE asynchronously, bus_req drops immediately, and no done pulse is issued.
- Minimum latency: req sampled at edge 0 → bus_req=1 in cycle 1. If bus_addr_ok is in cycle 1 and bus_data_ok in cycle 2, done=1 in cycle 3. Back-to-back transactions occur at most once every 4 cycles.
- stall_req is high from the first cycle a req is high until and excluding the done cycle; it is low in the done cycle.
- Bus fields change only on IDLE→ADDR transitions.
- No back-pressure limit: ADDR and DATA wait indefinitely for bus_addr_ok / bus_data_ok.

## Test plan
- **Single fetch:** i_req=1, i_addr=0xBFC0_0000; bus acks addr_ok in cycle 1 and data_ok in cycle 3 with rdata=0x3C08_0001.
  - Expect bus_addr=0x1FC0_0000, bus_size=10, bus_wr=0.
  - Expect i_done in cycle 4 with i_rdata=0x3C08_0001, stall_req low in cycle 4, and one bus_req assertion total.
- **Priority:** i_req and d_req (load, word, addr 0x8000_0010) rise together.
  - Expect the data transaction first (bus_addr=0x0000_0010), d_done, then the fetch starting in the cycle after d_done's RESP.
  - Expect i_done at least 8 cycles after the requests rise (4-cycle minimum per transaction, data transaction served first).
- **Store:** d_wr=1, d_wstrb=0011, d_size=01, d_wdata=0x0000_ABCD, addr=0x0000_2002 (unmapped).
  - Expect bus fields passed unchanged, d_done pulsed, and d_rdata unchanged from its previous value.
- **Slow bus:** hold bus_addr_ok low for 5 cycles, then bus_data_ok 7 cycles later.
  - Expect bus fields stable throughout, bus_req high exactly while in ADDR, and stall_req high for the whole wait.
- **Reset mid-transaction:** assert reset in DATA.
  - Expect bus_req=0, all outputs at reset values, and no done pulse.
  - After deasserting reset with i_req held, expect a fresh transaction to start.
- **Spurious handshakes:** drive bus_data_ok in IDLE and in ADDR, and bus_addr_ok in DATA.
  - Expect no state change and no done pulse.
